// File: rtl/wb_pkg.sv
// Shared constants for the writeback port arbiter: default widths, FSM state
// encoding and destination-mux select encoding.
package wb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  typedef enum logic {
    PRI_A   = 1'b0,
    FORCE_B = 1'b1
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/wb_out_reg.sv
// Registered output stage of the writeback arbiter: holds sel/waddr/wdata of the
// last grant and pulses we for one cycle after each accepted write.
module wb_out_reg
  import wb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          load_we,
  input  logic          load_sel,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          sel,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
);

  // Capture the granted write; payload is retained when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= SEL_A;
      we    <= 1'b0;
      waddr <= {AW{1'b0}};
      wdata <= {DW{1'b0}};
    end else begin
      we <= load & load_we;
      if (load) begin
        sel   <= load_sel;
        waddr <= load_addr;
        wdata <= load_data;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: fixed priority to A with a starvation guard for B.
// Optional build macro WB_ZERO_SUPPRESS_EN blocks the write enable for address 0.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          sel,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic [3:0]    conflict_cnt
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  arb_state_t    state_r, state_nxt_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  logic          conflict_s, a_ready_s, b_ready_s;
  logic          grant_s, grant_we_s, grant_sel_s;
  logic [AW-1:0] grant_addr_s;
  logic [DW-1:0] grant_data_s;

  assign conflict_s = a_valid & b_valid & ~hold;

  // Handshake readies from the current priority state.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if (!rst_n || hold) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else begin
      case (state_r)
        PRI_A: begin
          a_ready_s = a_valid;
          b_ready_s = b_valid & ~a_valid;
        end
        FORCE_B: begin
          b_ready_s = b_valid;
          a_ready_s = a_valid & ~b_valid;
        end
        default: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b0;
        end
      endcase
    end
  end

  // Next state and B wait counter; FORCE_B always lasts a single unheld cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (hold) begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end else begin
      case (state_r)
        PRI_A: begin
          if (conflict_s) begin
            cnt_nxt_s = cnt_r + 4'd1;
            if (cnt_r == WAIT_LAST) begin
              state_nxt_s = FORCE_B;
            end else begin
              state_nxt_s = PRI_A;
            end
          end else begin
            state_nxt_s = PRI_A;
            cnt_nxt_s   = 4'd0;
          end
        end
        FORCE_B: begin
          state_nxt_s = PRI_A;
          cnt_nxt_s   = 4'd0;
        end
        default: begin
          state_nxt_s = PRI_A;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PRI_A;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign grant_s      = a_ready_s | b_ready_s;
  assign grant_sel_s  = b_ready_s ? SEL_B : SEL_A;
  assign grant_addr_s = b_ready_s ? b_addr : a_addr;
  assign grant_data_s = b_ready_s ? b_data : a_data;

`ifdef WB_ZERO_SUPPRESS_EN
  assign grant_we_s = (grant_addr_s != {AW{1'b0}});
`else
  assign grant_we_s = 1'b1;
`endif

  wb_out_reg #(
    .AW(AW),
    .DW(DW)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_s),
    .load_we  (grant_we_s),
    .load_sel (grant_sel_s),
    .load_addr(grant_addr_s),
    .load_data(grant_data_s),
    .sel      (sel),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  assign a_ready      = a_ready_s;
  assign b_ready      = b_ready_s;
  assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a behavioural model predicts readies,
// wait count and the write stream; a negedge monitor checks each write.
module tb_wb_port_arbiter;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 3;

  logic          clk = 1'b0;
  logic          rst_n, hold;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, sel, we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    conflict_cnt;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  m_losses;
  bit  m_force;
  bit  last_a_acc, last_b_acc;

  wb_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .we(we), .waddr(waddr), .wdata(wdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_losses = 0;
    m_force  = 1'b0;
    exp_q.delete();
  endtask

  // One cycle: inputs already applied at posedge+1; predict, compare, advance.
  task automatic step();
    bit  ea, eb;
    wr_t w;
    #2;
    ea = 1'b0;
    eb = 1'b0;
    if (!hold) begin
      if (m_force) begin
        eb = b_valid;
        ea = a_valid && !b_valid;
        m_force  = 1'b0;
        m_losses = 0;
      end else begin
        ea = a_valid;
        eb = b_valid && !a_valid;
        if (a_valid && b_valid) begin
          m_losses++;
          if (m_losses == MAX_WAIT) m_force = 1'b1;
        end else begin
          m_losses = 0;
        end
      end
    end
    check("a_ready", {31'd0, a_ready}, {31'd0, ea});
    check("b_ready", {31'd0, b_ready}, {31'd0, eb});
    if (ea || eb) begin
      w.sel  = eb;
      w.addr = eb ? b_addr : a_addr;
      w.data = eb ? b_data : a_data;
`ifdef WB_ZERO_SUPPRESS_EN
      if (w.addr != 5'd0) exp_q.push_back(w);
`else
      exp_q.push_back(w);
`endif
    end
    last_a_acc = ea;
    last_b_acc = eb;
    @(posedge clk);
    #1;
    check("conflict_cnt", {28'd0, conflict_cnt}, m_losses);
  endtask

  task automatic new_a();
    a_addr = AW'($urandom);
    a_data = $urandom;
  endtask

  task automatic new_b();
    b_addr = AW'($urandom);
    b_data = $urandom;
  endtask

  // Write monitor: every we pulse must match the oldest predicted write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got waddr %0h wdata %0h, expected no write", waddr, wdata);
        end else begin
          w = exp_q.pop_front();
          check("sel", {31'd0, sel}, {31'd0, w.sel});
          check("waddr", {27'd0, waddr}, {27'd0, w.addr});
          check("wdata", wdata, w.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    new_a(); new_b();
    model_reset();
    #12;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_waddr", {27'd0, waddr}, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    check("rst_cnt", {28'd0, conflict_cnt}, 32'd0);
    #9;
    rst_n = 1'b1;
    step();

    // Single A then single B
    a_valid = 1'b1; a_addr = 5'b01010; a_data = 32'h0000_1234; b_valid = 1'b0;
    step();
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 5'b10101; b_data = $urandom;
    step();
    b_valid = 1'b0;
    step();

    // Starvation: both requesters held high
    a_valid = 1'b1; b_valid = 1'b1; new_a(); new_b();
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_a_acc) new_a();
      if (last_b_acc) new_b();
    end

    // Hold freezes arbitration mid-count
    step();
    if (last_a_acc) new_a();
    if (last_b_acc) new_b();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step();
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_a_acc) new_a();
      if (last_b_acc) new_b();
    end

    // Address-zero write from A
    b_valid = 1'b0; a_valid = 1'b1; a_addr = 5'd0; a_data = $urandom;
    step();
    a_valid = 1'b0;
    step();

    // Randomized traffic honouring the hold-until-ready rule
    for (int i = 0; i < 500; i++) begin
      if (!(a_valid && !last_a_acc)) begin
        a_valid = ($urandom_range(0, 2) != 0);
        new_a();
        if ($urandom_range(0, 15) == 0) a_addr = 5'd0;
      end
      if (!(b_valid && !last_b_acc)) begin
        b_valid = ($urandom_range(0, 2) != 0);
        new_b();
      end
      hold = ($urandom_range(0, 7) == 0);
      step();
    end

    // Reset asserted with a write in flight
    hold = 1'b0; a_valid = 1'b1; b_valid = 1'b0; a_addr = 5'd7; a_data = $urandom;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_we", {31'd0, we}, 32'd0);
    check("midrst_waddr", {27'd0, waddr}, 32'd0);
    check("midrst_a_ready", {31'd0, a_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    new_a(); b_valid = 1'b1; new_b();
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_a_acc) new_a();
      if (last_b_acc) new_b();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();
    check("pending_writes", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: A (ALU result, rd/rt destination) and B (load/multi-cycle result).
- Drives the select of the 5-bit destination mux in front of the register file, plus the write enable, address and data.
- Fixed priority to A, with a starvation guard that forces a B grant after a bounded number of lost conflicts.
- Outputs are registered, so the grant decision and the register-file write are cleanly pipelined.

Parameters:
- AW, 5, register address width (matches the mux width).
- DW, 32, write data width.
- MAX_WAIT, 3, consecutive conflict cycles B may lose before a forced grant (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- hold  input  1  register-file write port unavailable; no grants issued.
- a_valid  input  1  A has a pending write.
- a_addr  input  AW  A destination register.
- a_data  input  DW  A write data.
- a_ready  output  1  A accepted this cycle (combinational).
- b_valid  input  1  B has a pending write.
- b_addr  input  AW  B destination register.
- b_data  input  DW  B write data.
- b_ready  output  1  B accepted this cycle (combinational).
- sel  output  1  mux select, registered; 0 = A address, 1 = B address.
- we  output  1  register-file write enable, registered.
- waddr  output  AW  registered write address (mirrors the mux output).
- wdata  output  DW  registered write data.
- conflict_cnt  output  4  current B wait count (debug).

Behaviour:
- Reset (async, rst_n=0): sel=0, we=0, waddr=0, wdata=0, conflict_cnt=0, FSM=PRI_A. a_ready and b_ready are 0 whenever rst_n=0.
- Handshake: a transfer occurs on a clock edge where valid&ready=1. Requesters hold valid, addr and data stable until ready.
- FSM states:
  - PRI_A:
    - a_ready = a_valid & ~hold.
    - b_ready = b_valid & ~a_valid & ~hold.
  - FORCE_B:
    - b_ready = b_valid & ~hold.
    - a_ready = a_valid & ~b_valid & ~hold.
- Conflict = a_valid & b_valid & ~hold.
- Conflict counting in PRI_A:
  - Each conflict cycle increments conflict_cnt.
  - When conflict_cnt reaches MAX_WAIT-1 during a conflict, the next state is FORCE_B.
  - Any cycle with b accepted, or with b_valid=0, clears conflict_cnt.
- FORCE_B leaves after one B transfer: next state PRI_A, conflict_cnt=0.
  - If b_valid drops while in FORCE_B, return to PRI_A with conflict_cnt=0.
- hold=1: no ready asserted, state and conflict_cnt frozen, we=0 next cycle.
- Latency: accept at edge N gives we=1 with the matching sel/waddr/wdata during cycle N+1. Throughput is one write per cycle.
- No accept in a cycle: we=0 next cycle. sel, waddr and wdata retain their last values.
- sel follows the granted requester: 0 for A, 1 for B.
- Reset asserted mid-operation: outputs clear immediately (async). Any in-flight write is dropped, and requesters must re-present.

Optional Feature:
- Macro WB_ZERO_SUPPRESS_EN.
  - Defined: an accepted transfer whose address is 0 is still handshaken (ready=1), but we stays 0 the next cycle, so $zero is never written.
  - Undefined: address-0 writes pass through like any other write; the register file is responsible for ignoring them.

Decomposition:
- Shared package (wb_pkg): AW/DW constants, FSM state encoding (PRI_A=1'b0, FORCE_B=1'b1), select encoding constants SEL_A=0 and SEL_B=1.
- One natural sub-module, wb_out_reg: the registered output stage (sel/we/waddr/wdata) with async clear. The arbiter FSM and counter stay in the top.
- The 5-bit address mux itself stays a separate existing block. This arbiter drives its select, and waddr is a registered copy of the mux result for checking.

Test Plan:
- Reset: rst_n=0 for 20 ns with a_valid=b_valid=1 -> we=0, sel=0, waddr=0, a_ready=b_ready=0. Release -> A granted on the first edge.
- Single A: a_valid=1, a_addr=5'b01010, a_data=32'h1234 for one cycle -> next cycle we=1, sel=0, waddr=01010, wdata=32'h1234.
- Single B: b_valid=1, b_addr=5'b10101 -> b_ready=1 the same cycle. Next cycle we=1, sel=1, waddr=10101.
- Starvation: a_valid and b_valid held high, MAX_WAIT=3 -> grant sequence A, A, A, B, A, A, A, B. conflict_cnt goes 1, 2, then the FSM enters FORCE_B.
- Hold: both valid, hold=1 for 3 cycles -> no ready, we=0, conflict_cnt unchanged. After release, arbitration resumes from the frozen count.
- Zero suppress (macro defined): a_addr=5'b00000 accepted -> a_ready=1, next cycle we=0. With the macro undefined -> we=1, waddr=0.
